pipe_hazard_unit: RTL

//  Parametrised hazard/forwarding controller for the pipelined ARM CPU (IF/RF/EX/MEM/WB).

---
 rtl/pipe_hazard_unit_pkg.sv | 25 ++
 rtl/pipe_hazard_unit_if.sv | 29 ++
 rtl/pipe_hazard_unit_sat_counter.sv | 22 ++
 rtl/pipe_hazard_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the hazard/forwarding controller: scoreboard entry,
// forward-select encoding and the source-match predicate used for both operands.
package pipe_hazard_unit_pkg;

  localparam int HZ_RW    = 5;
  localparam int HZ_DEPTH = 3;
  localparam int FSEL_W   = $clog2(HZ_DEPTH + 1);

  typedef logic [FSEL_W-1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF = '0;

  typedef struct packed {
    logic             valid;
    logic [HZ_RW-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             set_flags;
  } entry_t;

  function automatic logic src_match(entry_t e, logic [HZ_RW-1:0] rs,
                                     logic [HZ_RW-1:0] zero_reg, logic used);
    return e.valid && e.reg_write && (e.rd == rs) && (rs != zero_reg) && used;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// RF-stage request and pipeline-control response bundle of the hazard unit.
interface pipe_hazard_unit_if #(
  parameter int RW    = pipe_hazard_unit_pkg::HZ_RW,
  parameter int DEPTH = pipe_hazard_unit_pkg::HZ_DEPTH,
  parameter int CNT_W = 16
);
  localparam int FW = $clog2(DEPTH + 1);

  logic          id_valid;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_rs1_used, id_rs2_used;
  logic          id_reg_write, id_mem_read, id_set_flags, id_flag_use;
  logic          br_taken;
  logic [FW-1:0] fwd_a, fwd_b;
  logic          stall, flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_reg_write, id_mem_read, id_set_flags, id_flag_use, br_taken,
    input  fwd_a, fwd_b, stall, flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_reg_write, id_mem_read, id_set_flags, id_flag_use, br_taken,
    output fwd_a, fwd_b, stall, flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller beside the RF stage: scoreboard of in-flight
// destinations, per-operand forward selects, load-use/flag stalls, branch flush.
module pipe_hazard_unit import pipe_hazard_unit_pkg::*; #(
  parameter int RW         = HZ_RW,
  parameter int DEPTH      = HZ_DEPTH,
  parameter int ZERO_REG   = 31,
  parameter int LOAD_READY = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_unit_if.slave hz
);
  localparam int               FW   = $clog2(DEPTH + 1);
  localparam logic [RW-1:0]    ZR_W = RW'(ZERO_REG);
  localparam logic [HZ_RW-1:0] ZR   = HZ_RW'(ZR_W);

  entry_t           ent_q [DEPTH];
  entry_t           ent0_d;
  logic [FW-1:0]    sel_a, sel_b, fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
  logic [HZ_RW-1:0] rs1, rs2;
  logic             ld_use, flag_stall, stall, flush, advance;

  assign rs1 = HZ_RW'(hz.id_rs1);
  assign rs2 = HZ_RW'(hz.id_rs2);

  // Walk oldest to youngest so the youngest producer overwrites the select.
  // A load that is not yet forwardable requests a stall and leaves the select at RF.
  always_comb begin
    ld_use = 1'b0;
    sel_a  = FW'(FWD_RF);
    sel_b  = FW'(FWD_RF);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_match(ent_q[k], rs1, ZR, hz.id_rs1_used)) begin
        if (ent_q[k].mem_read && (k < LOAD_READY)) begin
          ld_use = 1'b1;
          sel_a  = FW'(FWD_RF);
        end else begin
          sel_a  = FW'(k + 1);
        end
      end
      if (src_match(ent_q[k], rs2, ZR, hz.id_rs2_used)) begin
        if (ent_q[k].mem_read && (k < LOAD_READY)) begin
          ld_use = 1'b1;
          sel_b  = FW'(FWD_RF);
        end else begin
          sel_b  = FW'(k + 1);
        end
      end
    end
  end

  assign flag_stall = hz.id_flag_use && ent_q[0].valid && ent_q[0].set_flags;
  assign flush      = hz.br_taken;
  assign stall      = hz.id_valid && (ld_use || flag_stall) && !flush;
  assign advance    = hz.id_valid && !stall && !flush;

  always_comb begin
    ent0_d = '0;
    if (advance) begin
      ent0_d.valid     = 1'b1;
      ent0_d.rd        = HZ_RW'(hz.id_rd);
      ent0_d.reg_write = hz.id_reg_write;
      ent0_d.mem_read  = hz.id_mem_read;
      ent0_d.set_flags = hz.id_set_flags;
    end
  end

  assign fwd_a_d = advance ? sel_a : FW'(FWD_RF);
  assign fwd_b_d = advance ? sel_b : FW'(FWD_RF);

  // The scoreboard never freezes: stalls and flushes shift a bubble in.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      ent_q[0] <= ent0_d;
      for (int k = 1; k < DEPTH; k++) ent_q[k] <= ent_q[k-1];
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(reset), .inc_i(stall), .cnt_o(hz.stall_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(reset), .inc_i(flush), .cnt_o(hz.flush_cnt)
  );

  assign hz.fwd_a = fwd_a_q;
  assign hz.fwd_b = fwd_b_q;
  assign hz.stall = stall;
  assign hz.flush = flush;
endmodule
